mem_access_unit: RTL

MEM-stage load/store engine. It consumes the memory control fields decoded in ID (MemRW, RWType) together with the EX-stage ALU address and the rs2 store data, and runs a req/ack transaction on the data bus. It produces sign- or zero-extended load data for WB and stalls the pipeline while a transaction is outstanding.

---
 rtl/mem_access_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine driving a req/ack data bus with load extraction.
// Optional bus timeout enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_access_unit #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic              mem_en_i,
    input  logic              mem_rw_i,
    input  logic [2:0]        rw_type_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              stall_o,
    output logic [31:0]       load_data_o,
    output logic              load_valid_o,
    output logic              fault_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_be_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [31:0]       bus_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state, state_nx;
    logic        legal, aligned, access, start, bad, expire;
    logic [1:0]  off;
    logic [2:0]  typ;
    logic [31:0] ld_q, ext, wdata_nx;
    logic [3:0]  be_nx;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        legal = mem_rw_i ? (rw_type_i inside {3'b000, 3'b001, 3'b010})
                         : (rw_type_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        aligned = rw_type_i[1:0] == 2'b01 ? ~addr_i[0] :
                  rw_type_i[1:0] == 2'b10 ? addr_i[1:0] == 2'b00 : 1'b1;
        access = valid_i & mem_en_i;
        start = access & legal & aligned;
        bad = access & ~(legal & aligned);
    end

    // store lanes are replicated so the bus only needs byte enables to pick the slot
    always_comb begin
        be_nx = !mem_rw_i ? 4'hf :
                rw_type_i[1:0] == 2'b00 ? 4'b0001 << addr_i[1:0] :
                rw_type_i[1:0] == 2'b01 ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'hf;
        wdata_nx = !mem_rw_i ? 32'h0 :
                   rw_type_i[1:0] == 2'b00 ? {4{wdata_i[7:0]}} :
                   rw_type_i[1:0] == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
    end

    always_comb begin
        byte_sel = bus_rdata_i[8*off +: 8];
        half_sel = bus_rdata_i[16*off[1] +: 16];
        ext = typ == 3'b000 ? {{24{byte_sel[7]}}, byte_sel} :
              typ == 3'b001 ? {{16{half_sel[15]}}, half_sel} :
              typ == 3'b100 ? {24'h0, byte_sel} :
              typ == 3'b101 ? {16'h0, half_sel} : bus_rdata_i;
    end

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    assign expire = state == REQ && !bus_ack_i && cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (state != REQ)
            cnt <= '0;
        else if (!bus_ack_i)
            cnt <= cnt + 1'b1;
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;

    always_comb begin
        state_nx = state == IDLE ? (start ? REQ : IDLE) :
                   state == REQ  ? ((bus_ack_i | expire) ? DONE : REQ) : IDLE;
        stall_o = (state == IDLE & start) | state == REQ;
        bus_req_o = state == REQ;
        fault_o = (state == IDLE & bad) | expire;
        load_valid_o = (state == IDLE & bad & ~mem_rw_i) | (state == DONE & ~bus_we_o);
        load_data_o = state == DONE ? ld_q : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= 4'h0;
            bus_wdata_o <= 32'h0;
            off         <= 2'b00;
            typ         <= 3'b000;
            ld_q        <= 32'h0;
        end else if (state == IDLE && start) begin
            bus_we_o    <= mem_rw_i;
            bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
            bus_be_o    <= be_nx;
            bus_wdata_o <= wdata_nx;
            off         <= addr_i[1:0];
            typ         <= rw_type_i;
            ld_q        <= 32'h0;
        end else if (state == REQ && bus_ack_i) begin
            ld_q <= bus_we_o ? 32'h0 : ext;
        end else if (expire) begin
            ld_q <= 32'h0;
        end
endmodule
